// File: rtl/spi_slave_if.sv
// SPI slave endpoint: 2-FF oversampled pins, valid/ready RX word port, one-deep TX holding register.
// Optional SPI_SLAVE_REPEAT_LAST_EN: on TX underrun resend the last word taken from holding instead of g_fill_word.
module spi_slave_if #(
    parameter int unsigned                g_word_length = 32,
    parameter bit                         g_cpol        = 1'b0,
    parameter bit                         g_cpha        = 1'b0,
    parameter logic [g_word_length-1:0]   g_fill_word   = '0
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     spi_ssel_i,
    input  logic                     spi_sck_i,
    input  logic                     spi_mosi_i,
    output logic                     spi_miso_o,
    input  logic [g_word_length-1:0] tx_data_i,
    input  logic                     tx_valid_i,
    output logic                     tx_ready_o,
    output logic [g_word_length-1:0] rx_data_o,
    output logic                     rx_valid_o,
    input  logic                     rx_ready_i,
    output logic                     rx_overrun_o,
    output logic                     tx_underrun_o,
    output logic                     busy_o
);

    localparam int unsigned             c_cnt_w    = $clog2(g_word_length);
    localparam logic [c_cnt_w-1:0]      c_last_bit = c_cnt_w'(g_word_length - 1);

    typedef enum logic [0:0] {
        st_idle   = 1'b0,
        st_active = 1'b1
    } state_t;

    logic                     ssel_s1_r, ssel_s2_r, ssel_d_r;
    logic                     sck_s1_r, sck_s2_r, sck_d_r;
    logic                     mosi_s1_r, mosi_s2_r;
    logic                     settle_r, armed_r;

    state_t                   state_r;
    logic [c_cnt_w-1:0]       bit_cnt_r;
    logic [g_word_length-2:0] rx_shift_r;
    logic [g_word_length-1:0] tx_shift_r;
    logic                     miso_r, busy_r;
    logic [g_word_length-1:0] rx_data_r;
    logic                     rx_valid_r, rx_overrun_r;
    logic [g_word_length-1:0] hold_r;
    logic                     tx_ready_r, tx_underrun_r;

    logic                     sck_lead_s, sck_trail_s, ssel_fall_s, ssel_rise_s;
    logic                     sample_s, shift_s, word_done_s, load_s, tx_accept_s;
    logic [g_word_length-1:0] rx_next_s, reload_s, load_word_s;

    // Pin synchronizers; armed_r blocks a frame start until ssel has been seen high after reset.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            ssel_s1_r <= 1'b1;
            ssel_s2_r <= 1'b1;
            ssel_d_r  <= 1'b1;
            sck_s1_r  <= g_cpol;
            sck_s2_r  <= g_cpol;
            sck_d_r   <= g_cpol;
            mosi_s1_r <= 1'b0;
            mosi_s2_r <= 1'b0;
            settle_r  <= 1'b0;
            armed_r   <= 1'b0;
        end else begin
            ssel_s1_r <= spi_ssel_i;
            ssel_s2_r <= ssel_s1_r;
            ssel_d_r  <= ssel_s2_r;
            sck_s1_r  <= spi_sck_i;
            sck_s2_r  <= sck_s1_r;
            sck_d_r   <= sck_s2_r;
            mosi_s1_r <= spi_mosi_i;
            mosi_s2_r <= mosi_s1_r;
            settle_r  <= 1'b1;
            armed_r   <= armed_r | (settle_r & ssel_s1_r & ssel_s2_r);
        end
    end

    // Edge events and word-boundary decode.
    always_comb begin
        sck_lead_s  = (sck_s2_r != g_cpol) && (sck_d_r == g_cpol);
        sck_trail_s = (sck_s2_r == g_cpol) && (sck_d_r != g_cpol);
        ssel_fall_s = armed_r && !ssel_s2_r && ssel_d_r;
        ssel_rise_s = ssel_s2_r && !ssel_d_r;
        if (g_cpha) begin
            sample_s = sck_trail_s;
            shift_s  = sck_lead_s;
        end else begin
            sample_s = sck_lead_s;
            shift_s  = sck_trail_s;
        end
        rx_next_s   = {rx_shift_r, mosi_s2_r};
        word_done_s = (state_r == st_active) && !ssel_rise_s && sample_s && (bit_cnt_r == c_last_bit);
        load_s      = ((state_r == st_idle) && ssel_fall_s) || word_done_s;
        tx_accept_s = tx_valid_i && tx_ready_r;
        load_word_s = tx_ready_r ? reload_s : hold_r;
    end

`ifdef SPI_SLAVE_REPEAT_LAST_EN
    logic [g_word_length-1:0] last_r;

    // Last word moved from holding into the shifter; it is what an underrun repeats.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            last_r <= g_fill_word;
        end else if (load_s && !tx_ready_r) begin
            last_r <= hold_r;
        end
    end

    assign reload_s = last_r;
`else
    assign reload_s = g_fill_word;
`endif

    // Frame state machine with bit counter, shift registers and MISO driver.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_r    <= st_idle;
            busy_r     <= 1'b0;
            bit_cnt_r  <= '0;
            rx_shift_r <= '0;
            tx_shift_r <= '0;
            miso_r     <= 1'b0;
        end else begin
            case (state_r)
                st_idle: begin
                    if (ssel_fall_s) begin
                        state_r    <= st_active;
                        busy_r     <= 1'b1;
                        bit_cnt_r  <= '0;
                        rx_shift_r <= '0;
                        tx_shift_r <= load_word_s;
                        if (!g_cpha) begin
                            miso_r <= load_word_s[g_word_length-1];
                        end
                    end
                end
                st_active: begin
                    if (ssel_rise_s) begin
                        state_r    <= st_idle;
                        busy_r     <= 1'b0;
                        miso_r     <= 1'b0;
                        bit_cnt_r  <= '0;
                        rx_shift_r <= '0;
                        tx_shift_r <= '0;
                    end else if (sample_s) begin
                        if (bit_cnt_r == c_last_bit) begin
                            bit_cnt_r  <= '0;
                            rx_shift_r <= '0;
                            tx_shift_r <= load_word_s;
                            if (!g_cpha) begin
                                miso_r <= load_word_s[g_word_length-1];
                            end
                        end else begin
                            bit_cnt_r  <= bit_cnt_r + c_cnt_w'(1);
                            rx_shift_r <= rx_next_s[g_word_length-2:0];
                        end
                    end else if (shift_s) begin
                        // In CPHA=0 the trailing edge after the last sample must keep the freshly loaded MSB.
                        if (g_cpha || (bit_cnt_r != '0)) begin
                            miso_r     <= g_cpha ? tx_shift_r[g_word_length-1] : tx_shift_r[g_word_length-2];
                            tx_shift_r <= {tx_shift_r[g_word_length-2:0], 1'b0};
                        end
                    end
                end
                default: begin
                    state_r <= st_idle;
                    busy_r  <= 1'b0;
                    miso_r  <= 1'b0;
                end
            endcase
        end
    end

    // TX holding register: a LOAD drains it before any same-cycle write is considered.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            hold_r        <= '0;
            tx_ready_r    <= 1'b1;
            tx_underrun_r <= 1'b0;
        end else begin
            tx_underrun_r <= load_s && tx_ready_r;
            if (load_s && !tx_ready_r) begin
                tx_ready_r <= 1'b1;
            end else if (tx_accept_s) begin
                hold_r     <= tx_data_i;
                tx_ready_r <= 1'b0;
            end
        end
    end

    // RX word register with valid/ready handshake and overrun flag.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            rx_data_r    <= '0;
            rx_valid_r   <= 1'b0;
            rx_overrun_r <= 1'b0;
        end else begin
            rx_overrun_r <= word_done_s && rx_valid_r && !rx_ready_i;
            if (word_done_s) begin
                rx_data_r  <= rx_next_s;
                rx_valid_r <= 1'b1;
            end else if (rx_ready_i) begin
                rx_valid_r <= 1'b0;
            end
        end
    end

    assign spi_miso_o    = miso_r;
    assign tx_ready_o    = tx_ready_r;
    assign rx_data_o     = rx_data_r;
    assign rx_valid_o    = rx_valid_r;
    assign rx_overrun_o  = rx_overrun_r;
    assign tx_underrun_o = tx_underrun_r;
    assign busy_o        = busy_r;

endmodule
